// File: rtl/kb_pkg.sv
// Shared constants and types for the PS/2 keyboard host-side block.
package kb_pkg;

  localparam logic [7:0] KbAck      = 8'hFA;
  localparam logic [7:0] KbResend   = 8'hFE;
  localparam logic [7:0] KbCmdLed   = 8'hED;
  localparam logic [7:0] KbCmdReset = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap,
    StWait
  } kb_state_e;

endpackage

// File: rtl/kb_host_if.sv
// Bundle between kb_host and its environment (PS/2 controller side and CPU side).
interface kb_host_if #(
  parameter int unsigned DepthLog2 = 4
);
  logic                 kdone;
  logic [7:0]           ascii;
  logic                 hit;
  logic [7:0]           kbd;
  logic                 err;
  logic                 ready;
  logic                 cmd;
  logic [7:0]           dat;
  logic                 rd_pop;
  logic [7:0]           rd_data;
  logic                 rd_empty;
  logic [DepthLog2:0]   count;
  logic                 overflow;
  logic                 ovf_clr;
  logic                 cpu_cmd_we;
  logic [7:0]           cpu_cmd_dat;
  logic                 cmd_busy;
  logic                 cmd_ok;
  logic                 cmd_fail;

  modport master (
    output kdone, ascii, hit, kbd, err, ready, rd_pop, ovf_clr, cpu_cmd_we, cpu_cmd_dat,
    input  cmd, dat, rd_data, rd_empty, count, overflow, cmd_busy, cmd_ok, cmd_fail
  );

  modport slave (
    input  kdone, ascii, hit, kbd, err, ready, rd_pop, ovf_clr, cpu_cmd_we, cpu_cmd_dat,
    output cmd, dat, rd_data, rd_empty, count, overflow, cmd_busy, cmd_ok, cmd_fail
  );

endinterface

// File: rtl/kb_fifo.sv
// Synchronous show-ahead FIFO with occupancy count and sticky overflow flag.
module kb_fifo #(
  parameter int unsigned DepthLog2 = 4,
  parameter int unsigned Width     = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [Width-1:0]     wdata,
  input  logic                 pop,
  output logic [Width-1:0]     rdata,
  output logic                 empty,
  output logic [DepthLog2:0]   count,
  input  logic                 ovf_clr,
  output logic                 overflow
);

  localparam int unsigned Depth = 2 ** DepthLog2;

  logic [Width-1:0]     mem_q [Depth];
  logic [DepthLog2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DepthLog2:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (DepthLog2 + 1)'(Depth));
  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (DepthLog2 + 1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (DepthLog2 + 1)'(1);
    end
    if (push && !do_push) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + DepthLog2'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + DepthLog2'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata    = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/kb_host.sv
// CPU-side keyboard host: keystroke FIFO plus host-to-keyboard command sequencer.
module kb_host
  import kb_pkg::*;
#(
  parameter int unsigned DepthLog2  = 4,
  parameter int unsigned AckTimeout = 250000,
  parameter int unsigned Retries    = 3
) (
  input logic       clock,
  input logic       reset_n,
  kb_host_if.slave  bus
);

  localparam int unsigned TimerW = $clog2(AckTimeout + 1);
  localparam int unsigned TriesW = $clog2(Retries + 2);

  kb_state_e         state_q, state_d;
  logic [7:0]        byte_q, byte_d;
  logic [TriesW-1:0] tries_q, tries_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              cmd_q, cmd_d;
  logic [7:0]        dat_q, dat_d;
  logic              ok_q, ok_d;
  logic              fail_q, fail_d;
  logic              err_q;
  logic              ack, nak;

  kb_fifo #(
    .DepthLog2 (DepthLog2),
    .Width     (8)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (bus.kdone),
    .wdata    (bus.ascii),
    .pop      (bus.rd_pop),
    .rdata    (bus.rd_data),
    .empty    (bus.rd_empty),
    .count    (bus.count),
    .ovf_clr  (bus.ovf_clr),
    .overflow (bus.overflow)
  );

  assign ack = bus.hit && (bus.kbd == KbAck);
  assign nak = (bus.hit && (bus.kbd == KbResend)) || (bus.err && !err_q);

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    tries_d = tries_q;
    timer_d = timer_q;
    cmd_d   = 1'b0;
    dat_d   = dat_q;
    ok_d    = ok_q;
    fail_d  = fail_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cpu_cmd_we) begin
          byte_d  = bus.cpu_cmd_dat;
          tries_d = '0;
          ok_d    = 1'b0;
          fail_d  = 1'b0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (bus.ready) begin
          cmd_d   = 1'b1;
          dat_d   = byte_q;
          timer_d = '0;
          state_d = StGap;
        end
      end
      // Timer counts from the cmd pulse, so the GAP cycle is included in the timeout.
      StGap: begin
        timer_d = timer_q + TimerW'(1);
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + TimerW'(1);
        if (ack) begin
          ok_d    = 1'b1;
          state_d = StIdle;
        end else if (nak) begin
          if (tries_q < TriesW'(Retries)) begin
            tries_d = tries_q + TriesW'(1);
            state_d = StSend;
          end else begin
            fail_d  = 1'b1;
            state_d = StIdle;
          end
        end else if (timer_q == TimerW'(AckTimeout - 1)) begin
          fail_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      byte_q  <= '0;
      tries_q <= '0;
      timer_q <= '0;
      cmd_q   <= 1'b0;
      dat_q   <= '0;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
      cmd_q   <= cmd_d;
      dat_q   <= dat_d;
      ok_q    <= ok_d;
      fail_q  <= fail_d;
      err_q   <= bus.err;
    end
  end

  assign bus.cmd      = cmd_q;
  assign bus.dat      = dat_q;
  assign bus.cmd_busy = (state_q != StIdle);
  assign bus.cmd_ok   = ok_q;
  assign bus.cmd_fail = fail_q;

endmodule

// File: tb/tb_kb_host.sv
// Scoreboard bench for kb_host: directed stimulus, queued expectations, negedge monitor.
module tb_kb_host;
  import kb_pkg::*;

  localparam int unsigned AckT = 200;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;

  logic [7:0] exp_cmd[$];
  logic [7:0] exp_rd[$];
  logic [1:0] exp_stat[$];  // {ok, fail} when busy drops

  kb_host_if #(.DepthLog2(4)) kb ();

  kb_host #(
    .DepthLog2  (4),
    .AckTimeout (AckT),
    .Retries    (3)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (kb)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_key(input logic [7:0] b);
    kb.kdone = 1'b1;
    kb.ascii = b;
    tick();
    kb.kdone = 1'b0;
  endtask

  task automatic pop_key();
    kb.rd_pop = 1'b1;
    tick();
    kb.rd_pop = 1'b0;
  endtask

  task automatic send_hit(input logic [7:0] b);
    kb.hit = 1'b1;
    kb.kbd = b;
    tick();
    kb.hit = 1'b0;
  endtask

  task automatic cpu_cmd(input logic [7:0] b);
    kb.cpu_cmd_we  = 1'b1;
    kb.cpu_cmd_dat = b;
    tick();
    kb.cpu_cmd_we  = 1'b0;
  endtask

  task automatic wait_cmd(input string name);
    int n = 0;
    while (kb.cmd !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(name, {31'd0, kb.cmd}, 32'd1);
  endtask

  // Monitor: compares every DUT-presented event against the queued expectation.
  logic prev_busy = 1'b0;
  logic prev_rstn = 1'b0;
  always @(negedge clock) begin
    if (reset_n && kb.cmd === 1'b1) begin
      pulses++;
      if (exp_cmd.size() == 0) check("unexpected cmd pulse", {24'd0, kb.dat}, 32'hDEAD);
      else check("cmd dat", {24'd0, kb.dat}, {24'd0, exp_cmd.pop_front()});
    end
    if (reset_n && kb.rd_pop === 1'b1 && kb.rd_empty === 1'b0) begin
      if (exp_rd.size() == 0) check("unexpected pop", {24'd0, kb.rd_data}, 32'hDEAD);
      else check("rd_data", {24'd0, kb.rd_data}, {24'd0, exp_rd.pop_front()});
    end
    if (reset_n && prev_rstn && prev_busy === 1'b1 && kb.cmd_busy === 1'b0) begin
      if (exp_stat.size() == 0) check("unexpected completion", {30'd0, kb.cmd_ok, kb.cmd_fail}, 32'hDEAD);
      else check("cmd status ok/fail", {30'd0, kb.cmd_ok, kb.cmd_fail}, {30'd0, exp_stat.pop_front()});
    end
    prev_busy = kb.cmd_busy;
    prev_rstn = reset_n;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cnt;
    kb.kdone = 0; kb.ascii = 0; kb.hit = 0; kb.kbd = 0; kb.err = 0; kb.ready = 1;
    kb.rd_pop = 0; kb.ovf_clr = 0; kb.cpu_cmd_we = 0; kb.cpu_cmd_dat = 0;
    tick(); tick();
    reset_n = 1'b1;
    check("reset count", {27'd0, kb.count}, 0);
    check("reset rd_empty", {31'd0, kb.rd_empty}, 1);
    check("reset overflow", {31'd0, kb.overflow}, 0);
    check("reset cmd", {31'd0, kb.cmd}, 0);
    check("reset dat", {24'd0, kb.dat}, 0);
    check("reset busy/ok/fail", {29'd0, kb.cmd_busy, kb.cmd_ok, kb.cmd_fail}, 0);

    // Basic push then drain, plus a pop on empty.
    push_key(8'h61); push_key(8'h62); push_key(8'h63);
    check("count after 3", {27'd0, kb.count}, 3);
    check("head after 3", {24'd0, kb.rd_data}, 32'h61);
    exp_rd.push_back(8'h61); exp_rd.push_back(8'h62); exp_rd.push_back(8'h63);
    pop_key(); pop_key(); pop_key();
    check("empty after drain", {31'd0, kb.rd_empty}, 1);
    pop_key();
    check("count after empty pop", {27'd0, kb.count}, 0);

    // Fill past full, clear overflow, push+pop while full.
    for (int i = 0; i < 17; i++) push_key(8'(i));
    check("count full", {27'd0, kb.count}, 16);
    check("overflow set", {31'd0, kb.overflow}, 1);
    check("head full", {24'd0, kb.rd_data}, 0);
    kb.ovf_clr = 1'b1; tick(); kb.ovf_clr = 1'b0;
    check("overflow cleared", {31'd0, kb.overflow}, 0);
    exp_rd.push_back(8'h00);
    kb.kdone = 1'b1; kb.ascii = 8'h55; kb.rd_pop = 1'b1;
    tick();
    kb.kdone = 1'b0; kb.rd_pop = 1'b0;
    check("count push+pop full", {27'd0, kb.count}, 16);
    check("no overflow push+pop", {31'd0, kb.overflow}, 0);
    for (int i = 1; i < 16; i++) exp_rd.push_back(8'(i));
    exp_rd.push_back(8'h55);
    for (int i = 0; i < 16; i++) pop_key();
    check("empty after full drain", {31'd0, kb.rd_empty}, 1);

    // LED command, held off by ready=0, ACKed after 100 clocks.
    kb.ready = 1'b0;
    exp_cmd.push_back(KbCmdLed);
    base = pulses;
    cpu_cmd(KbCmdLed);
    check("busy after we", {31'd0, kb.cmd_busy}, 1);
    repeat (5) tick();
    check("no cmd while not ready", pulses - base, 0);
    kb.ready = 1'b1;
    wait_cmd("led cmd pulse");
    repeat (40) tick();
    push_key(8'h31);
    send_hit(8'hAA);
    repeat (57) tick();
    check("busy ignores other hit", {31'd0, kb.cmd_busy}, 1);
    exp_stat.push_back(2'b10);
    send_hit(KbAck);
    check("led ok", {30'd0, kb.cmd_ok, kb.cmd_busy}, 32'b10);
    check("key during cmd", {27'd0, kb.count}, 1);
    exp_rd.push_back(8'h31);
    pop_key();

    // Reset command, RESEND four times -> fail after 1+Retries pulses.
    base = pulses;
    for (int i = 0; i < 4; i++) exp_cmd.push_back(KbCmdReset);
    exp_stat.push_back(2'b01);
    cpu_cmd(KbCmdReset);
    check("ok cleared on new cmd", {31'd0, kb.cmd_ok}, 0);
    for (int i = 0; i < 4; i++) begin
      wait_cmd("reset cmd pulse");
      repeat (3) tick();
      send_hit(KbResend);
    end
    repeat (10) tick();
    check("resend pulse count", pulses - base, 4);
    check("resend fail", {30'd0, kb.cmd_ok, kb.cmd_fail}, 32'b01);

    // Timeout, with an ignored second write while busy.
    exp_cmd.push_back(8'hF4);
    exp_stat.push_back(2'b01);
    cpu_cmd(8'hF4);
    wait_cmd("timeout cmd pulse");
    cnt = 0;
    while (kb.cmd_fail !== 1'b1 && cnt < int'(AckT) + 20) begin
      kb.cpu_cmd_we  = (cnt == 4);
      kb.cpu_cmd_dat = KbCmdLed;
      tick();
      cnt++;
    end
    kb.cpu_cmd_we = 1'b0;
    check("timeout latency", cnt, AckT);

    // err rising edge retries once; a held level does not retrigger.
    exp_cmd.push_back(8'hF6); exp_cmd.push_back(8'hF6);
    exp_stat.push_back(2'b10);
    cpu_cmd(8'hF6);
    wait_cmd("err cmd pulse 1");
    repeat (3) tick();
    kb.err = 1'b1;
    wait_cmd("err cmd pulse 2");
    repeat (3) tick();
    send_hit(KbAck);
    kb.err = 1'b0;
    check("err retry then ok", {30'd0, kb.cmd_ok, kb.cmd_fail}, 32'b10);

    // Reset mid-WAIT with a partly full FIFO.
    for (int i = 0; i < 5; i++) push_key(8'h70 + 8'(i));
    exp_cmd.push_back(KbCmdLed);
    cpu_cmd(KbCmdLed);
    wait_cmd("pre-reset cmd pulse");
    repeat (3) tick();
    check("count before reset", {27'd0, kb.count}, 5);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("count after mid reset", {27'd0, kb.count}, 0);
    check("busy/cmd after mid reset", {30'd0, kb.cmd_busy, kb.cmd}, 0);
    push_key(8'h41);
    check("head after reset", {24'd0, kb.rd_data}, 32'h41);
    repeat (5) tick();

    check("cmd queue drained", exp_cmd.size(), 0);
    check("status queue drained", exp_stat.size(), 0);
    check("rd queue drained", exp_rd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kb_host.md
Name: kb_host

Overview:
CPU-side companion to the PS/2 keyboard controller, sitting between that controller and the AVR I/O register file.
- Buffers decoded ASCII keystrokes (kdone/ascii) in a small FIFO so the CPU can poll at its own pace.
- Sequences host-to-keyboard commands (LED set, reset, typematic), tracking the keyboard's ACK (0xFA) / RESEND (0xFE) replies with retry and timeout.
- Reports status flags to the CPU.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (16)
ACK_TIMEOUT, 250000, clocks to wait for a reply after issuing a command (10 ms at 25 MHz)
RETRIES, 3, extra attempts after a RESEND reply or error before failing

Ports:
clock  in  1  25 MHz system clock, rising edge
reset_n  in  1  reset, synchronous, active-low
kdone  in  1  one-clock strobe: ascii valid (key-down)
ascii  in  8  decoded key code
hit  in  1  one-clock strobe: raw byte kbd received with good parity
kbd  in  8  raw received byte
err  in  1  controller error/timeout flag (level)
ready  in  1  controller can accept cmd
cmd  out  1  one-clock command strobe to controller
dat  out  8  command byte to controller, valid with cmd
rd_pop  in  1  CPU pop strobe
rd_data  out  8  FIFO head (show-ahead)
rd_empty  out  1  FIFO empty
count  out  DEPTH_LOG2+1  FIFO occupancy
overflow  out  1  sticky: key dropped because FIFO full
ovf_clr  in  1  clears overflow
cpu_cmd_we  in  1  CPU command write strobe
cpu_cmd_dat  in  8  command byte
cmd_busy  out  1  command sequence in progress
cmd_ok  out  1  last command ACKed (sticky until next cpu_cmd_we)
cmd_fail  out  1  last command failed (sticky until next cpu_cmd_we)

Behaviour:
Reset (reset_n=0 at a rising edge):
- Pointers, count, overflow, cmd, cmd_busy, cmd_ok and cmd_fail all go to 0; rd_empty=1; dat=0x00; FSM enters IDLE.
- rd_data contents are don't-care while empty.
- Reset aborts any sequence in progress. No cmd strobe is issued in the cycle after reset.

Input sampling: all inputs are sampled on the rising edge. Each kb strobe is high for exactly one clock.

FIFO:
- Push on kdone; pop on rd_pop && !rd_empty.
- rd_data = head entry, combinational from storage. Valid in the cycle after the push that made the FIFO non-empty.
- Push and pop in the same cycle: both take effect and count is unchanged. This holds when full: head leaves, new entry is written, no overflow.
- Push while full without pop: entry dropped, overflow<=1, count stays at 2**DEPTH_LOG2.
- Pop while empty: ignored, count stays 0.
- Pointers wrap modulo depth; count is the extra-bit occupancy (0..16).
- ovf_clr and an overflow event in the same cycle: overflow=1 (set wins).

Command FSM:
- IDLE
  - On cpu_cmd_we: latch cpu_cmd_dat, tries<=0, cmd_busy<=1, cmd_ok<=0, cmd_fail<=0 -> SEND.
  - cpu_cmd_we while cmd_busy=1 is ignored.
- SEND
  - When ready=1: cmd=1 for one clock, dat=latched byte, timer<=0 -> GAP. Otherwise wait.
- GAP
  - One clock, no checks, so the controller's ready drops -> WAIT.
- WAIT (timer increments every clock)
  - hit && kbd==0xFA: cmd_ok<=1, cmd_busy<=0 -> IDLE.
  - hit && kbd==0xFE, or err rising edge: if tries<RETRIES then tries<=tries+1 -> SEND; else cmd_fail<=1, cmd_busy<=0 -> IDLE.
  - timer==ACK_TIMEOUT-1: cmd_fail<=1, cmd_busy<=0 -> IDLE. No retry on timeout.
  - Any other hit byte is ignored.
  - Same-cycle hit and timeout: the hit wins.

Independence: keystrokes arriving during a command sequence are still pushed; the FIFO and FSM are independent. Raw hit bytes never enter the FIFO.

Decomposition:
- Shared package kb_pkg holds:
  - constants KB_ACK=8'hFA, KB_RESEND=8'hFE, KB_CMD_LED=8'hED, KB_CMD_RESET=8'hFF;
  - the FSM state enum {IDLE, SEND, GAP, WAIT}.
- One sub-module is natural: kb_fifo (parameterised sync show-ahead FIFO with count and overflow). The command FSM stays in kb_host.

Test Plan:
- Reset, then kdone with ascii 0x61,0x62,0x63 -> count=3, rd_data=0x61; three rd_pop -> 0x62, 0x63, then rd_empty=1, count=0.
- 17 kdone pushes 0x00..0x10, no pop -> count=16, overflow=1, rd_data=0x00, byte 0x10 lost. ovf_clr -> overflow=0. Push+pop same cycle while full -> count=16, overflow stays 0.
- cpu_cmd_we 0xED with ready=1 -> exactly one cmd pulse with dat=0xED in SEND+0. hit with kbd=0xFA 100 clocks later -> cmd_ok=1, cmd_busy=0.
- 0xFF command answered by 0xFE four times -> four cmd pulses total (1+RETRIES), then cmd_fail=1, cmd_ok=0.
- Command with no reply -> cmd_fail=1 exactly ACK_TIMEOUT clocks after the cmd pulse. A second cpu_cmd_we during busy produces no extra cmd pulse.
- reset_n low mid-WAIT with FIFO count=5 -> next cycle count=0, cmd_busy=0, cmd=0. A subsequent kdone 0x41 -> rd_data=0x41.
